// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu: multi-cycle, width-parametrised ALU with a start/busy/done
// handshake. MUL is an iterative radix-2 Booth multiplier (one step per
// cycle), DIV an iterative signed restoring divider (one step per cycle plus
// a sign-fix cycle). All other ops take one compute cycle.
//
// Handshake: start is sampled on a rising edge only while busy=0 (IDLE or
// DONE). a, b and op are captured on that edge; busy stays high until the
// result is ready, then done pulses for exactly one cycle with result and
// div_zero valid. result/div_zero hold until the next done. start while busy
// is dropped, not queued.
//
// Ports:
//   clk       in   1        rising-edge clock
//   clr       in   1        synchronous active-high reset, aborts any op
//   start     in   1        launch op
//   op        in   5        opcode
//   a         in   WIDTH    operand A
//   b         in   WIDTH    operand B; b[SHW-1:0] is the shift/rotate amount
//   busy      out  1        op in progress
//   done      out  1        one-cycle pulse, result valid
//   result    out  2*WIDTH  {HI,LO}
//   div_zero  out  1        valid with done: DIV had b==0
//   dbg_state out  3        current FSM state
// ---------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [4:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_zero,
  output logic [2:0]         dbg_state
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [SHW:0]     CNT_W   = (SHW+1)'(WIDTH);
  localparam logic [SHW:0]     CNT_ONE = (SHW+1)'(1);

  // CALC is the single compute cycle of the one-cycle ops (incl. div by 0).
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_DFIX = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [4:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  // Booth register {HI (WIDTH+1 bits), LO multiplier, appended bit}. HI has
  // one guard bit so adding/subtracting -2^(WIDTH-1) cannot overflow.
  logic [2*WIDTH+1:0]   booth_q, booth_d;
  // Divider: quot_q starts as |a| and shifts dividend bits out / quotient in.
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quot_q, quot_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic [SHW:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 dz_q, dz_d;

  // Single-cycle datapath (works from captured operands).
  logic [WIDTH-1:0]     sc_lo, sc_hi;
  logic                 sc_dz;
  logic [SHW-1:0]       amt;
  logic [SHW:0]         amt_inv;

  always_comb begin
    amt     = b_q[SHW-1:0];
    amt_inv = CNT_W - {1'b0, amt};
    sc_lo   = '0;
    sc_hi   = '0;
    sc_dz   = 1'b0;
    case (op_q)
      OP_ADD: begin
        sc_lo = a_q + b_q;
        sc_hi = {WIDTH{sc_lo[WIDTH-1]}};
      end
      OP_SUB: begin
        sc_lo = a_q - b_q;
        sc_hi = {WIDTH{sc_lo[WIDTH-1]}};
      end
      OP_AND:  sc_lo = a_q & b_q;
      OP_OR:   sc_lo = a_q | b_q;
      OP_SHR:  sc_lo = a_q >> amt;
      OP_SHRA: sc_lo = $signed(a_q) >>> amt;
      OP_SHL:  sc_lo = a_q << amt;
      // Shift by WIDTH yields zero, so amount 0 returns a unchanged.
      OP_ROR:  sc_lo = (a_q >> amt) | (a_q << amt_inv);
      OP_ROL:  sc_lo = (a_q << amt) | (a_q >> amt_inv);
      OP_NEG:  sc_lo = ~a_q + ONE_W;
      OP_NOT:  sc_lo = ~a_q;
      // Only reached with b==0: nonzero divisors go through the DIV states.
      OP_DIV: begin
        sc_lo = '1;
        sc_hi = a_q;
        sc_dz = 1'b1;
      end
      default: begin
        sc_lo = '0;
        sc_hi = '0;
      end
    endcase
  end

  // Booth step and restoring-divide step.
  logic [WIDTH:0]       bh, mext;
  logic [2*WIDTH+1:0]   booth_nx;
  logic [WIDTH:0]       dshift, dtrial;

  always_comb begin
    mext = {b_q[WIDTH-1], b_q};
    bh   = booth_q[2*WIDTH+1:WIDTH+1];
    case (booth_q[1:0])
      2'b01:   bh = bh + mext;
      2'b10:   bh = bh - mext;
      default: bh = booth_q[2*WIDTH+1:WIDTH+1];
    endcase
    booth_nx = {bh[WIDTH], bh, booth_q[WIDTH:1]};

    dshift = {rem_q, quot_q[WIDTH-1]};
    dtrial = dshift - {1'b0, dvs_q};
  end

  logic launch;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    booth_d  = booth_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dz_d     = dz_q;
    launch   = start && (state_q == S_IDLE || state_q == S_DONE);

    case (state_q)
      S_CALC: begin
        result_d = {sc_hi, sc_lo};
        dz_d     = sc_dz;
        state_d  = S_DONE;
      end
      S_MUL: begin
        booth_d = booth_nx;
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d = booth_nx[2*WIDTH:1];
          dz_d     = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        // Negative trial means the divisor did not fit: keep the shifted value.
        if (dtrial[WIDTH]) begin
          rem_d  = dshift[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d  = dtrial[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_DFIX;
      end
      S_DFIX: begin
        // Quotient negative iff signs differ; remainder follows the dividend.
        // -2^(W-1)/-1 naturally gives quotient 2^(W-1), i.e. -2^(W-1).
        result_d[WIDTH-1:0]       = qneg_q ? (~quot_q + ONE_W) : quot_q;
        result_d[2*WIDTH-1:WIDTH] = rneg_q ? (~rem_q + ONE_W) : rem_q;
        dz_d    = 1'b0;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = state_q;
    endcase

    if (launch) begin
      op_d = op;
      a_d  = a;
      b_d  = b;
      if (op == OP_MUL) begin
        booth_d = {{(WIDTH+1){1'b0}}, a, 1'b0};
        cnt_d   = CNT_W;
        state_d = S_MUL;
      end else if (op == OP_DIV && b != '0) begin
        rem_d   = '0;
        quot_d  = a[WIDTH-1] ? (~a + ONE_W) : a;
        dvs_d   = b[WIDTH-1] ? (~b + ONE_W) : b;
        qneg_d  = a[WIDTH-1] ^ b[WIDTH-1];
        rneg_d  = a[WIDTH-1];
        cnt_d   = CNT_W;
        state_d = S_DIV;
      end else begin
        state_d = S_CALC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      booth_q  <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      booth_q  <= booth_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dz_q     <= dz_d;
    end
  end

  assign busy      = (state_q == S_CALC) || (state_q == S_MUL) ||
                     (state_q == S_DIV)  || (state_q == S_DFIX);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign div_zero  = dz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu: directed test of seq_alu at WIDTH=32, 8 and 64. Three
// instances share clk/clr; each has its own stimulus and output signals.
// Latency k is counted in cycles after the start edge: k=0 is the cycle
// right after the edge that samples start.
// ---------------------------------------------------------------------------
module tb_seq_alu;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // ---------------- clock / reset ----------------
  logic clk;
  logic clr;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        start32, busy32, done32, dz32;
  logic [4:0]  op32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic [2:0]  st32;

  logic        start8, busy8, done8, dz8;
  logic [4:0]  op8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic [2:0]  st8;

  logic         start64, busy64, done64, dz64;
  logic [4:0]   op64;
  logic [63:0]  a64, b64;
  logic [127:0] res64;
  logic [2:0]   st64;

  seq_alu #(.WIDTH(32)) u_dut32 (
    .clk(clk), .clr(clr), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(res32), .div_zero(dz32),
    .dbg_state(st32)
  );
  seq_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .clr(clr), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .div_zero(dz8),
    .dbg_state(st8)
  );
  seq_alu #(.WIDTH(64)) u_dut64 (
    .clk(clk), .clr(clr), .start(start64), .op(op64), .a(a64), .b(b64),
    .busy(busy64), .done(done64), .result(res64), .div_zero(dz64),
    .dbg_state(st64)
  );

  // ---------------- scoreboard state ----------------
  int total;
  int bad;
  logic [127:0] last_exp [3];

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- DUT access helpers ----------------
  function automatic logic [127:0] res_of(input int sel);
    case (sel)
      0:       return {64'b0, res32};
      1:       return {112'b0, res8};
      default: return res64;
    endcase
  endfunction

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return done32;
      1:       return done8;
      default: return done64;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return busy32;
      1:       return busy8;
      default: return busy64;
    endcase
  endfunction

  function automatic logic dz_of(input int sel);
    case (sel)
      0:       return dz32;
      1:       return dz8;
      default: return dz64;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input logic st, input logic [4:0] o,
                       input logic [63:0] av, input logic [63:0] bv);
    case (sel)
      0: begin start32 = st; op32 = o; a32 = av[31:0]; b32 = bv[31:0]; end
      1: begin start8  = st; op8  = o; a8  = av[7:0];  b8  = bv[7:0];  end
      default: begin start64 = st; op64 = o; a64 = av; b64 = bv; end
    endcase
  endtask

  // Launch one op, scramble the inputs after the start edge, then check
  // busy, result hold, latency, result, div_zero and the one-cycle pulse.
  task automatic run_op(input int sel, input logic [4:0] o,
                        input logic [63:0] av, input logic [63:0] bv,
                        input logic [127:0] exp_r, input logic exp_dz,
                        input int exp_lat, input string tag);
    int k;
    @(negedge clk);
    drive(sel, 1'b1, o, av, bv);
    @(negedge clk);
    drive(sel, 1'b0, OP_ADD, ~av, ~bv);
    check({tag, "_busy"}, {127'b0, busy_of(sel)}, 128'd1);
    check({tag, "_hold"}, res_of(sel), last_exp[sel]);
    k = 0;
    while (!done_of(sel) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 128'(k), 128'(exp_lat));
    check({tag, "_res"}, res_of(sel), exp_r);
    check({tag, "_dz"}, {127'b0, dz_of(sel)}, {127'b0, exp_dz});
    last_exp[sel] = exp_r;
    @(negedge clk);
    check({tag, "_pulse"}, {127'b0, done_of(sel)}, 128'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    int pulses;
    logic [127:0] seen_res;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 3; i++) last_exp[i] = '0;
    clr = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 5'b0, 64'b0, 64'b0);
    repeat (3) @(negedge clk);

    // Reset state of all three instances.
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d_busy", i), {127'b0, busy_of(i)}, 128'd0);
      check($sformatf("rst%0d_done", i), {127'b0, done_of(i)}, 128'd0);
      check($sformatf("rst%0d_res", i), res_of(i), 128'd0);
      check($sformatf("rst%0d_dz", i), {127'b0, dz_of(i)}, 128'd0);
    end
    clr = 1'b0;

    // Make result nonzero, then abort a MUL with clr at cycle 10.
    run_op(0, OP_ADD, 64'd5, 64'hFFFFFFF7, 128'hFFFFFFFF_FFFFFFFC, 1'b0, 1, "add32");
    @(negedge clk);
    drive(0, 1'b1, OP_MUL, 64'd5, 64'd7);
    @(negedge clk);
    drive(0, 1'b0, OP_ADD, 64'd0, 64'd0);
    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done32) pulses++;
    end
    check("clr_no_done", 128'(pulses), 128'd0);
    check("clr_busy", {127'b0, busy32}, 128'd0);
    check("clr_res", res_of(0), 128'd0);
    check("clr_dz", {127'b0, dz32}, 128'd0);
    for (int i = 0; i < 3; i++) last_exp[i] = '0;

    // WIDTH=32: multiply, divide, shifts/rotates, logic ops.
    run_op(0, OP_MUL, 64'hFFFFFFFD, 64'd7, 128'hFFFFFFFF_FFFFFFEB, 1'b0, 32, "mul32_a");
    run_op(0, OP_MUL, 64'h80000000, 64'h80000000, 128'h40000000_00000000, 1'b0, 32, "mul32_b");
    run_op(0, OP_DIV, 64'hFFFFFFF9, 64'd2, 128'hFFFFFFFF_FFFFFFFD, 1'b0, 33, "div32_a");
    run_op(0, OP_DIV, 64'd100, 64'd0, 128'h00000064_FFFFFFFF, 1'b1, 1, "div32_z");
    run_op(0, OP_DIV, 64'h80000000, 64'hFFFFFFFF, 128'h00000000_80000000, 1'b0, 33, "div32_ovf");
    run_op(0, OP_DIV, 64'd7, 64'hFFFFFFFE, 128'h00000001_FFFFFFFD, 1'b0, 33, "div32_b");
    run_op(0, OP_ROR, 64'h00000001, 64'd4, 128'h00000000_10000000, 1'b0, 1, "ror32");
    run_op(0, OP_SHRA, 64'h80000000, 64'd31, 128'h00000000_FFFFFFFF, 1'b0, 1, "shra32");
    run_op(0, OP_ROL, 64'h12345678, 64'h20, 128'h00000000_12345678, 1'b0, 1, "rol32_0");
    run_op(0, OP_ROL, 64'h80000001, 64'd1, 128'h00000000_00000003, 1'b0, 1, "rol32_1");
    run_op(0, OP_SHR, 64'hF0000000, 64'd4, 128'h00000000_0F000000, 1'b0, 1, "shr32");
    run_op(0, OP_SHL, 64'h0000000F, 64'd28, 128'h00000000_F0000000, 1'b0, 1, "shl32");
    run_op(0, OP_AND, 64'h0000F0F0, 64'h0000FF00, 128'h00000000_0000F000, 1'b0, 1, "and32");
    run_op(0, OP_OR, 64'h0000F0F0, 64'h0000FF00, 128'h00000000_0000FFF0, 1'b0, 1, "or32");
    run_op(0, OP_NOT, 64'h0, 64'h0, 128'h00000000_FFFFFFFF, 1'b0, 1, "not32");
    run_op(0, OP_NEG, 64'd5, 64'h0, 128'h00000000_FFFFFFFB, 1'b0, 1, "neg32");
    run_op(0, OP_SUB, 64'd3, 64'd5, 128'hFFFFFFFF_FFFFFFFE, 1'b0, 1, "sub32");
    run_op(0, 5'b11111, 64'd3, 64'd5, 128'h0, 1'b0, 1, "undef32");

    // Back-to-back: add, then sub launched in the DONE cycle.
    @(negedge clk);
    drive(0, 1'b1, OP_ADD, 64'd5, 64'hFFFFFFF7);
    @(negedge clk);
    drive(0, 1'b0, OP_ADD, 64'd0, 64'd0);
    k = 0;
    while (!done32 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("b2b_lat1", 128'(k), 128'd1);
    check("b2b_res1", res_of(0), 128'hFFFFFFFF_FFFFFFFC);
    drive(0, 1'b1, OP_SUB, 64'd5, 64'd9);
    @(negedge clk);
    drive(0, 1'b0, OP_ADD, 64'd0, 64'd0);
    check("b2b_gap", {127'b0, done32}, 128'd0);
    check("b2b_busy", {127'b0, busy32}, 128'd1);
    @(negedge clk);
    check("b2b_done2", {127'b0, done32}, 128'd1);
    check("b2b_res2", res_of(0), 128'hFFFFFFFF_FFFFFFFC);
    last_exp[0] = 128'hFFFFFFFF_FFFFFFFC;
    @(negedge clk);

    // start pulsed while a DIV is busy must be ignored.
    drive(0, 1'b1, OP_DIV, 64'd100, 64'd7);
    @(negedge clk);
    drive(0, 1'b0, OP_ADD, 64'd0, 64'd0);
    repeat (5) @(negedge clk);
    drive(0, 1'b1, OP_ADD, 64'd1, 64'd1);
    @(negedge clk);
    drive(0, 1'b0, OP_ADD, 64'd0, 64'd0);
    pulses   = 0;
    seen_res = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done32) begin
        pulses++;
        seen_res = res_of(0);
      end
    end
    check("ign_pulses", 128'(pulses), 128'd1);
    check("ign_res", seen_res, 128'h00000002_0000000E);
    last_exp[0] = 128'h00000002_0000000E;

    // WIDTH=8.
    run_op(1, OP_MUL, 64'hFD, 64'd7, 128'hFFEB, 1'b0, 8, "mul8_a");
    run_op(1, OP_MUL, 64'h80, 64'h80, 128'h4000, 1'b0, 8, "mul8_b");
    run_op(1, OP_DIV, 64'hF9, 64'd2, 128'hFFFD, 1'b0, 9, "div8_a");
    run_op(1, OP_DIV, 64'd100, 64'd0, 128'h64FF, 1'b1, 1, "div8_z");
    run_op(1, OP_ROR, 64'h01, 64'd4, 128'h0010, 1'b0, 1, "ror8");
    run_op(1, OP_SHRA, 64'h80, 64'd7, 128'h00FF, 1'b0, 1, "shra8");
    run_op(1, OP_ROL, 64'hA5, 64'h08, 128'h00A5, 1'b0, 1, "rol8_0");

    // WIDTH=64.
    run_op(2, OP_MUL, 64'hFFFFFFFFFFFFFFFD, 64'd7,
           128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFEB, 1'b0, 64, "mul64_a");
    run_op(2, OP_MUL, 64'h8000000000000000, 64'h8000000000000000,
           128'h4000000000000000_0000000000000000, 1'b0, 64, "mul64_b");
    run_op(2, OP_DIV, 64'hFFFFFFFFFFFFFFF9, 64'd2,
           128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFD, 1'b0, 65, "div64_a");
    run_op(2, OP_DIV, 64'd100, 64'd0,
           128'h0000000000000064_FFFFFFFFFFFFFFFF, 1'b1, 1, "div64_z");
    run_op(2, OP_ROR, 64'h1, 64'd4,
           128'h0000000000000000_1000000000000000, 1'b0, 1, "ror64");
    run_op(2, OP_SHRA, 64'h8000000000000000, 64'd63,
           128'h0000000000000000_FFFFFFFFFFFFFFFF, 1'b0, 1, "shra64");
    run_op(2, OP_ROL, 64'h0123456789ABCDEF, 64'h40,
           128'h0000000000000000_0123456789ABCDEF, 1'b0, 1, "rol64_0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
